// File: rtl/bus_datapath_pkg.sv
// Shared definitions for the bus datapath: source index offsets, read FSM states,
// and the bus source count derived from the GPR count.
package bus_datapath_pkg;

  // Special sources follow the GPRs on the bus, as offsets from NUM_GPR
  localparam int unsigned IDX_HI     = 0;
  localparam int unsigned IDX_LO     = 1;
  localparam int unsigned IDX_ZHI    = 2;
  localparam int unsigned IDX_ZLO    = 3;
  localparam int unsigned IDX_PC     = 4;
  localparam int unsigned IDX_MDR    = 5;
  localparam int unsigned IDX_INPORT = 6;
  localparam int unsigned NUM_SPECIAL = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  function automatic int unsigned num_src(input int unsigned num_gpr);
    return num_gpr + NUM_SPECIAL;
  endfunction

endpackage

// File: rtl/bus_datapath_core_if.sv
// Memory read handshake between the datapath (master) and the memory (slave).
interface bus_datapath_core_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              mem_req;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, output mem_ack, output mem_rdata);
endinterface

// File: rtl/bus_datapath_reg.sv
// Storage element with asynchronous active-low clear and load enable.
module bus_datapath_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/bus_datapath_core.sv
// Shared-bus datapath: GPRs, HI/LO, Z pair, PC, MDR with timed memory read, INPORT, MAR/IR/Y.
// Optional build macro R0_ZERO_EN makes R0 a constant zero.
module bus_datapath_core
  import bus_datapath_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_GPR     = 16,
  parameter int unsigned PC_STEP     = 1,
  parameter int unsigned MEM_TIMEOUT = 15,
  localparam int unsigned NUM_SRC    = num_src(NUM_GPR)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NUM_SRC-1:0]    rin,
  input  logic [NUM_SRC-1:0]    rout,
  input  logic                  mar_in,
  input  logic                  ir_in,
  input  logic                  y_in,
  input  logic                  z_in,
  input  logic                  pc_inc,
  input  logic [2*DATA_W-1:0]   alu_result,
  input  logic [DATA_W-1:0]     inport_data,
  input  logic                  mem_rd_start,
  bus_datapath_core_if.master   mem,
  output logic [DATA_W-1:0]     mar_q,
  output logic [DATA_W-1:0]     ir_q,
  output logic [DATA_W-1:0]     y_q,
  output logic [DATA_W-1:0]     bus,
  output logic                  mdr_busy,
  output logic                  mem_err,
  output logic                  bus_err
);
  localparam int unsigned I_ZHI    = NUM_GPR + IDX_ZHI;
  localparam int unsigned I_ZLO    = NUM_GPR + IDX_ZLO;
  localparam int unsigned I_PC     = NUM_GPR + IDX_PC;
  localparam int unsigned I_MDR    = NUM_GPR + IDX_MDR;
  localparam int unsigned I_INPORT = NUM_GPR + IDX_INPORT;

  logic [DATA_W-1:0] src_d [NUM_SRC];
  logic [DATA_W-1:0] src_q [NUM_SRC];
  logic [NUM_SRC-1:0] src_en;
  logic [DATA_W-1:0] bus_d;
  logic              found;
  logic              bus_err_d, bus_err_q;
  rd_state_e         state_q;
  logic [7:0]        cnt_q;
  logic              mem_req_q, mdr_busy_q, mem_err_q;

  // Lowest-index driver wins when several rout bits are set
  always_comb begin
    bus_d = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (rout[i] && !found) begin
        bus_d = src_q[i];
        found = 1'b1;
      end
    end
  end

  assign bus_err_d = bus_err_q | (|(rout & (rout - NUM_SRC'(1))));

  always_comb begin
    src_en = rin;
    for (int unsigned i = 0; i < NUM_SRC; i++) src_d[i] = bus_d;
`ifdef R0_ZERO_EN
    // R0 never loads, so it holds its reset value of zero
    src_en[0] = 1'b0;
`endif
    src_en[I_INPORT] = 1'b1;
    if (!rin[I_INPORT]) src_d[I_INPORT] = inport_data;
    if (!rin[I_PC] && pc_inc) begin
      src_d[I_PC]  = src_q[I_PC] + DATA_W'(PC_STEP);
      src_en[I_PC] = 1'b1;
    end
    if (z_in) begin
      src_d[I_ZHI]  = alu_result[2*DATA_W-1:DATA_W];
      src_d[I_ZLO]  = alu_result[DATA_W-1:0];
      src_en[I_ZHI] = 1'b1;
      src_en[I_ZLO] = 1'b1;
    end
    // The read FSM owns MDR whenever it is not idle
    src_en[I_MDR] = rin[I_MDR] && (state_q == IDLE);
    if (state_q == WAIT && mem.mem_ack) begin
      src_d[I_MDR]  = mem.mem_rdata;
      src_en[I_MDR] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    bus_datapath_reg #(.W(DATA_W)) u_src (
      .clock(clock), .clear(clear), .en(src_en[g]), .d(src_d[g]), .q(src_q[g])
    );
  end

  bus_datapath_reg #(.W(DATA_W)) u_mar (
    .clock(clock), .clear(clear), .en(mar_in), .d(bus_d), .q(mar_q)
  );
  bus_datapath_reg #(.W(DATA_W)) u_ir (
    .clock(clock), .clear(clear), .en(ir_in), .d(bus_d), .q(ir_q)
  );
  bus_datapath_reg #(.W(DATA_W)) u_y (
    .clock(clock), .clear(clear), .en(y_in), .d(bus_d), .q(y_q)
  );
  bus_datapath_reg #(.W(1)) u_bus_err (
    .clock(clock), .clear(clear), .en(1'b1), .d(bus_err_d), .q(bus_err_q)
  );

  // An ack in the final WAIT cycle is checked before the timeout, so it succeeds
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mdr_busy_q <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mem_rd_start) begin
          state_q    <= REQ;
          mem_req_q  <= 1'b1;
          mdr_busy_q <= 1'b1;
        end
        REQ: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem.mem_ack) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
          end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            mem_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          mdr_busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_req = mem_req_q;
  assign mdr_busy    = mdr_busy_q;
  assign mem_err     = mem_err_q;
  assign bus_err     = bus_err_q;
  assign bus         = bus_d;
endmodule

// File: tb/tb_bus_datapath_core.sv
// Directed bench for bus_datapath_core (default parameters); R0 expectation follows R0_ZERO_EN.
module tb_bus_datapath_core;
  localparam int NS       = 23;
  localparam int I_ZHI    = 18;
  localparam int I_ZLO    = 19;
  localparam int I_PC     = 20;
  localparam int I_MDR    = 21;
  localparam int I_INPORT = 22;

  logic          clock = 1'b0;
  logic          clear;
  logic [NS-1:0] rin, rout;
  logic          mar_in, ir_in, y_in, z_in, pc_inc, mem_rd_start;
  logic [63:0]   alu_result;
  logic [31:0]   inport_data;
  logic [31:0]   mar_q, ir_q, y_q, bus;
  logic          mdr_busy, mem_err, bus_err;
  int            total = 0;
  int            bad = 0;
  int            hi_cnt;

  bus_datapath_core_if #(.DATA_W(32)) mem_if ();

  bus_datapath_core #(
    .DATA_W(32), .NUM_GPR(16), .PC_STEP(1), .MEM_TIMEOUT(15)
  ) dut (
    .clock(clock), .clear(clear), .rin(rin), .rout(rout),
    .mar_in(mar_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .pc_inc(pc_inc),
    .alu_result(alu_result), .inport_data(inport_data), .mem_rd_start(mem_rd_start),
    .mem(mem_if), .mar_q(mar_q), .ir_q(ir_q), .y_q(y_q), .bus(bus),
    .mdr_busy(mdr_busy), .mem_err(mem_err), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Load register idx through the INPORT register
  task automatic load_reg(input int idx, input logic [31:0] value);
    inport_data = value;
    rin = '0; rout = '0;
    step;
    rin[idx] = 1'b1; rout[I_INPORT] = 1'b1;
    step;
    rin = '0; rout = '0;
  endtask

  task automatic test_reset;
    clear = 1'b0;
    #3;
    total++; if (bus !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h exp=%h", bus, 32'h0); end
    total++; if (mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_if.mem_req); end
    total++; if (mdr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", mdr_busy); end
    total++; if (mem_err !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL reset_errs got=%b%b exp=00", mem_err, bus_err); end
    total++; if (mar_q !== 32'h0) begin bad++; $display("FAIL reset_mar got=%h exp=%h", mar_q, 32'h0); end
    rout[I_PC] = 1'b1;
    #1;
    total++; if (bus !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", bus, 32'h0); end
    rout = '0;
    step;
    clear = 1'b1;
  endtask

  task automatic test_load_drive;
    inport_data = 32'hDEADBEEF;
    step;
    rin[5] = 1'b1; rout[I_INPORT] = 1'b1;
    #1;
    total++; if (bus !== 32'hDEADBEEF) begin bad++; $display("FAIL inport_drive got=%h exp=%h", bus, 32'hDEADBEEF); end
    step;
    rin = '0; rout = '0; rout[5] = 1'b1;
    #1;
    total++; if (bus !== 32'hDEADBEEF) begin bad++; $display("FAIL r5_drive got=%h exp=%h", bus, 32'hDEADBEEF); end
    step;
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL single_no_err got=%b exp=0", bus_err); end
    rout = '0;
  endtask

  task automatic test_conflict;
    load_reg(3, 32'h11111111);
    load_reg(7, 32'h22222222);
    rout[3] = 1'b1; rout[7] = 1'b1;
    #1;
    total++; if (bus !== 32'h11111111) begin bad++; $display("FAIL conflict_bus got=%h exp=%h", bus, 32'h11111111); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL conflict_pre got=%b exp=0", bus_err); end
    step;
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL conflict_set got=%b exp=1", bus_err); end
    rout = '0;
    step; step;
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL conflict_sticky got=%b exp=1", bus_err); end
    clear = 1'b0;
    #1;
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL conflict_clear got=%b exp=0", bus_err); end
    step;
    clear = 1'b1;
  endtask

  task automatic test_pc;
    load_reg(I_PC, 32'hFFFFFFFF);
    pc_inc = 1'b1;
    step;
    pc_inc = 1'b0; rout[I_PC] = 1'b1;
    #1;
    total++; if (bus !== 32'h0) begin bad++; $display("FAIL pc_wrap got=%h exp=%h", bus, 32'h0); end
    rout = '0;
    inport_data = 32'h10;
    step;
    rout[I_INPORT] = 1'b1; rin[I_PC] = 1'b1; pc_inc = 1'b1;
    step;
    rin = '0; rout = '0; pc_inc = 1'b0; rout[I_PC] = 1'b1;
    #1;
    total++; if (bus !== 32'h10) begin bad++; $display("FAIL pc_load_wins got=%h exp=%h", bus, 32'h10); end
    pc_inc = 1'b1;
    step;
    pc_inc = 1'b0;
    total++; if (bus !== 32'h11) begin bad++; $display("FAIL pc_inc got=%h exp=%h", bus, 32'h11); end
    rout = '0;
  endtask

  task automatic test_alu;
    inport_data = 32'h77777777;
    step;
    rout[I_INPORT] = 1'b1; rin[I_ZHI] = 1'b1; rin[I_ZLO] = 1'b1;
    z_in = 1'b1; alu_result = 64'h0123456789ABCDEF;
    step;
    z_in = 1'b0; rin = '0; rout = '0; rout[I_ZHI] = 1'b1;
    #1;
    total++; if (bus !== 32'h01234567) begin bad++; $display("FAIL zhi got=%h exp=%h", bus, 32'h01234567); end
    rout = '0; rout[I_ZLO] = 1'b1;
    #1;
    total++; if (bus !== 32'h89ABCDEF) begin bad++; $display("FAIL zlo got=%h exp=%h", bus, 32'h89ABCDEF); end
    rout = '0; rout[I_INPORT] = 1'b1; rin[I_ZLO] = 1'b1;
    step;
    rin = '0; rout = '0; rout[I_ZLO] = 1'b1;
    #1;
    total++; if (bus !== 32'h77777777) begin bad++; $display("FAIL zlo_bus_load got=%h exp=%h", bus, 32'h77777777); end
    rout = '0;
  endtask

  task automatic test_mar_ir_y;
    inport_data = 32'hA5A5A5A5;
    step;
    rout[I_INPORT] = 1'b1; mar_in = 1'b1;
    step;
    mar_in = 1'b0; inport_data = 32'h3C3C3C3C;
    step;
    ir_in = 1'b1;
    step;
    ir_in = 1'b0;
    total++; if (mar_q !== 32'hA5A5A5A5) begin bad++; $display("FAIL mar got=%h exp=%h", mar_q, 32'hA5A5A5A5); end
    total++; if (ir_q !== 32'h3C3C3C3C) begin bad++; $display("FAIL ir got=%h exp=%h", ir_q, 32'h3C3C3C3C); end
    total++; if (y_q !== 32'h0) begin bad++; $display("FAIL y_idle got=%h exp=%h", y_q, 32'h0); end
    y_in = 1'b1;
    step;
    y_in = 1'b0; rout = '0;
    total++; if (y_q !== 32'h3C3C3C3C) begin bad++; $display("FAIL y got=%h exp=%h", y_q, 32'h3C3C3C3C); end
  endtask

  task automatic test_mem_read;
    load_reg(I_MDR, 32'h12345678);
    inport_data = 32'h55555555;
    mem_rd_start = 1'b1;
    hi_cnt = 0;
    step;
    mem_rd_start = 1'b0; hi_cnt += int'(mem_if.mem_req);
    total++; if (mdr_busy !== 1'b1) begin bad++; $display("FAIL rd_busy got=%b exp=1", mdr_busy); end
    rin[I_MDR] = 1'b1; rout[I_INPORT] = 1'b1;
    step;
    hi_cnt += int'(mem_if.mem_req);
    rin = '0; rout = '0; rout[I_MDR] = 1'b1;
    #1;
    total++; if (bus !== 32'h12345678) begin bad++; $display("FAIL rd_rin_ignored got=%h exp=%h", bus, 32'h12345678); end
    step; hi_cnt += int'(mem_if.mem_req);
    step; hi_cnt += int'(mem_if.mem_req);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hCAFEBABE;
    step; hi_cnt += int'(mem_if.mem_req);
    mem_if.mem_ack = 1'b0;
    total++; if (hi_cnt !== 4) begin bad++; $display("FAIL rd_req_cycles got=%0d exp=4", hi_cnt); end
    total++; if (mdr_busy !== 1'b1) begin bad++; $display("FAIL rd_done_busy got=%b exp=1", mdr_busy); end
    step;
    total++; if (mdr_busy !== 1'b0) begin bad++; $display("FAIL rd_idle got=%b exp=0", mdr_busy); end
    total++; if (bus !== 32'hCAFEBABE) begin bad++; $display("FAIL rd_mdr got=%h exp=%h", bus, 32'hCAFEBABE); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL rd_no_err got=%b exp=0", mem_err); end
    rout = '0;
  endtask

  task automatic test_timeout;
    mem_rd_start = 1'b1;
    step;
    mem_rd_start = 1'b0;
    for (int i = 0; i < 15; i++) step;
    total++; if (mem_err !== 1'b0 || mem_if.mem_req !== 1'b1) begin bad++; $display("FAIL to_early got=%b%b exp=01", mem_err, mem_if.mem_req); end
    step;
    total++; if (mem_err !== 1'b1 || mem_if.mem_req !== 1'b0) begin bad++; $display("FAIL to_fire got=%b%b exp=10", mem_err, mem_if.mem_req); end
    step;
    rout[I_MDR] = 1'b1;
    #1;
    total++; if (mdr_busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b exp=0", mdr_busy); end
    total++; if (bus !== 32'hCAFEBABE) begin bad++; $display("FAIL to_mdr_kept got=%h exp=%h", bus, 32'hCAFEBABE); end
    rout = '0;
    step;
    total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", mem_err); end
  endtask

  task automatic test_ack_at_timeout;
    clear = 1'b0;
    #1;
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL at_clear got=%b exp=0", mem_err); end
    step;
    clear = 1'b1;
    mem_rd_start = 1'b1;
    step;
    mem_rd_start = 1'b0;
    for (int i = 0; i < 15; i++) step;
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h0BADF00D;
    step;
    mem_if.mem_ack = 1'b0;
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL at_no_err got=%b exp=0", mem_err); end
    step;
    rout[I_MDR] = 1'b1;
    #1;
    total++; if (bus !== 32'h0BADF00D) begin bad++; $display("FAIL at_mdr got=%h exp=%h", bus, 32'h0BADF00D); end
    rout = '0;
  endtask

  task automatic test_reset_mid_read;
    mem_rd_start = 1'b1;
    step;
    mem_rd_start = 1'b0;
    step;
    total++; if (mem_if.mem_req !== 1'b1) begin bad++; $display("FAIL mid_req got=%b exp=1", mem_if.mem_req); end
    #2 clear = 1'b0;
    #1;
    total++; if (mem_if.mem_req !== 1'b0 || mdr_busy !== 1'b0) begin bad++; $display("FAIL mid_reset got=%b%b exp=00", mem_if.mem_req, mdr_busy); end
    step;
    clear = 1'b1;
  endtask

  task automatic test_r0;
    logic [31:0] exp_r0;
`ifdef R0_ZERO_EN
    exp_r0 = 32'h0;
`else
    exp_r0 = 32'hFFFFFFFF;
`endif
    load_reg(0, 32'hFFFFFFFF);
    rout[0] = 1'b1;
    #1;
    total++; if (bus !== exp_r0) begin bad++; $display("FAIL r0 got=%h exp=%h", bus, exp_r0); end
    rout = '0;
  endtask

  initial begin
    clear = 1'b0; rin = '0; rout = '0;
    mar_in = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0; pc_inc = 1'b0;
    mem_rd_start = 1'b0; alu_result = '0; inport_data = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    test_reset;
    test_load_drive;
    test_conflict;
    test_pc;
    test_alu;
    test_mar_ir_y;
    test_mem_read;
    test_timeout;
    test_ack_at_timeout;
    test_reset_mid_read;
    test_r0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_datapath_core.md
Name: bus_datapath_core

Overview:
- Parametrised successor of the phase-1 bus datapath: a general register file, HI/LO, Z pair, PC, MAR, IR, Y and MDR, all sharing one one-hot-selected internal bus.
- Adds PC auto-increment, a memory-read handshake FSM with timeout for MDR, a sticky bus-conflict flag and an external-ALU interface through Y and Z.
- Sits between the control unit (drives the strobes) and the ALU/memory.

Parameters:
- DATA_W, 32, width of bus and every register
- NUM_GPR, 16, number of general-purpose registers R0..R(NUM_GPR-1)
- PC_STEP, 1, PC increment per pc_inc pulse
- MEM_TIMEOUT, 15, max cycles waiting for mem_ack; valid range 1..255

Ports:
- clock  in  1  single clock, rising edge
- clear  in  1  asynchronous active-low reset
- rin  in  NUM_SRC  one-hot load enables; NUM_SRC = NUM_GPR+7
- rout  in  NUM_SRC  bus-drive selects, same index map as rin
- mar_in / ir_in / y_in  in  1  load MAR / IR / Y from bus
- z_in  in  1  load {ZHI,ZLO} from alu_result
- pc_inc  in  1  PC += PC_STEP
- alu_result  in  2*DATA_W  external ALU output
- inport_data  in  DATA_W  external input port
- mem_rd_start  in  1  start memory read into MDR
- mem_ack  in  1  memory data valid
- mem_rdata  in  DATA_W  memory read data
- mem_req  out  1  read request to memory
- mar_q / ir_q / y_q  out  DATA_W  register contents
- bus  out  DATA_W  internal bus value
- mdr_busy  out  1  read FSM not IDLE
- mem_err  out  1  sticky timeout flag
- bus_err  out  1  sticky multi-driver flag

Behaviour:
- Source index map: 0..NUM_GPR-1 GPRs, then HI, LO, ZHI, ZLO, PC, MDR, INPORT.
- Reset (clear=0, async): every register 0, FSM IDLE, mem_req/mdr_busy/mem_err/bus_err = 0.
- Bus is combinational.
  - rout all-zero gives bus = 0.
  - Exactly one bit set: that source drives the bus.
  - Two or more bits set: the lowest index drives the bus, and bus_err sets on the next edge and stays set until reset.
- Register load: on a rising edge with rin[i]=1, register i <= bus. Multiple rin bits load in parallel. Load and drive in the same cycle is allowed; the register captures the pre-edge bus value.
- INPORT register: if rin[INPORT] is set it loads from the bus; otherwise it samples inport_data every cycle.
- PC:
  - pc_inc gives PC <= PC + PC_STEP, modulo 2^DATA_W (wraps).
  - rin[PC] together with pc_inc: the bus load wins and the increment is dropped.
- z_in loads ZHI <= alu_result[2W-1:W] and ZLO <= alu_result[W-1:0]. If rin[ZHI]/rin[ZLO] is also set, z_in wins.
- MDR read FSM:
  - IDLE: on mem_rd_start, go to REQ.
  - REQ: mem_req=1, timeout counter cleared, go to WAIT.
  - WAIT:
    - mem_ack: MDR <= mem_rdata, go to DONE.
    - Counter reaching MEM_TIMEOUT: mem_err set, MDR unchanged, go to DONE.
  - DONE: mem_req=0, one cycle, return to IDLE.
  - mem_req is 1 in REQ and WAIT. mdr_busy is 1 in every state except IDLE.
  - mem_rd_start while busy is ignored.
  - rin[MDR] while busy is ignored; the FSM has write priority.
  - A mem_ack arriving in the same cycle the timeout fires counts as success.
  - Reset mid-read returns to IDLE and drops mem_req immediately.
- No pipelining: load latency is 1 edge, read latency is 0 (combinational bus).

Optional Feature:
- Macro: R0_ZERO_EN.
- Defined: R0 is hardwired 0; rin[0] is ignored and rout[0] drives 0.
- Undefined: R0 is an ordinary register.

Decomposition:
- Package bus_datapath_pkg holds:
  - source index localparams (IDX_HI etc. as offsets from NUM_GPR)
  - the FSM state enum {IDLE, REQ, WAIT, DONE}
  - NUM_SRC as a function of NUM_GPR
- One sub-module, bus_datapath_reg: DATA_W-wide register with async active-low clear and enable. Instantiate it for every storage element.
- The MDR FSM stays inline.

Test Plan:
- Reset, then rin[5]=1 with rout[INPORT]=1 and inport_data=DEADBEEF -> next cycle rout[5] gives bus=DEADBEEF; bus_err=0.
- rout[3] and rout[7] both set (R3=11111111, R7=22222222) -> bus=11111111; bus_err=1 next edge and stays set until clear.
- PC loaded FFFFFFFF, pc_inc pulse -> PC=00000000 (wrap); rin[PC] with bus=10 plus pc_inc -> PC=10.
- mem_rd_start, mem_ack 3 cycles later with mem_rdata=CAFEBABE -> MDR=CAFEBABE; mem_req high 4 cycles; mdr_busy drops after DONE.
- mem_rd_start with no ack -> mem_err=1 after MEM_TIMEOUT cycles in WAIT; MDR unchanged.
- alu_result=0123456789ABCDEF with z_in -> ZHI=01234567, ZLO=89ABCDEF.
- With R0_ZERO_EN: rin[0] with bus=FFFFFFFF -> rout[0] gives bus=0.
